// File: rtl/ahb_mtx_input_stage.sv
// Master-side input stage of the AHB bus matrix. It forwards the address phase
// live, or from a holding register while the output-stage arbiter withholds a grant.
module ahb_mtx_input_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_i,
  output logic [ADDR_W-1:0] addr_i,
  output logic [1:0]        trans_i,
  output logic              write_i,
  output logic [2:0]        size_i,
  output logic [2:0]        burst_i,
  output logic [3:0]        prot_i,
  output logic              mastlock_i,
  output logic              req_i,
  input  logic              active_i,
  input  logic              readyout_i,
  input  logic              resp_i
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              mastlock;
  } aph_t;

  typedef enum logic {S_IDLE, S_HELD} state_t;

  state_t state_q, state_d;
  aph_t   hold_q, live_aph, out_aph;
  logic   dphase_q, dphase_d;
  logic   held, new_xfer, capture;

  assign held     = (state_q == S_HELD);
  assign new_xfer = HSELS & HREADYS & HTRANSS[1];
  assign live_aph = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                      burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  // A new transfer seen while held is a protocol violation and is ignored.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (new_xfer && !active_i) begin
        state_d = S_HELD;
        capture = 1'b1;
      end
      S_HELD: if (active_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // An accept in the same cycle as completion keeps the data phase running.
  assign dphase_d = active_i | (dphase_q & ~readyout_i);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      dphase_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      dphase_q <= dphase_d;
      if (capture) hold_q <= live_aph;
    end
  end

  assign out_aph    = held ? hold_q : live_aph;
  assign sel_i      = held | HSELS;
  assign addr_i     = out_aph.addr;
  assign trans_i    = out_aph.trans;
  assign write_i    = out_aph.write;
  assign size_i     = out_aph.size;
  assign burst_i    = out_aph.burst;
  assign prot_i     = out_aph.prot;
  assign mastlock_i = out_aph.mastlock;
  assign req_i      = held | (HSELS & HTRANSS[1]);

  assign HREADYOUTS = held ? 1'b0 : (dphase_q ? readyout_i : 1'b1);
  assign HRESPS     = (dphase_q & ~held) ? resp_i : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed bench for ahb_mtx_input_stage: accepted transfers are scoreboarded
// against the address phase presented on the accept cycle.
module tb_ahb_mtx_input_stage;
  localparam int ADDR_W = 32;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;
  logic              sel_i;
  logic [ADDR_W-1:0] addr_i;
  logic [1:0]        trans_i;
  logic              write_i;
  logic [2:0]        size_i;
  logic [2:0]        burst_i;
  logic [3:0]        prot_i;
  logic              mastlock_i;
  logic              req_i;
  logic              active_i;
  logic              readyout_i;
  logic              resp_i;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              write;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  ahb_mtx_input_stage #(.ADDR_W(ADDR_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_i(sel_i), .addr_i(addr_i),
    .trans_i(trans_i), .write_i(write_i), .size_i(size_i), .burst_i(burst_i),
    .prot_i(prot_i), .mastlock_i(mastlock_i), .req_i(req_i), .active_i(active_i),
    .readyout_i(readyout_i), .resp_i(resp_i)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard on an accept cycle and compare the presented address phase.
  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed accept expected empty scoreboard", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_addr"}, 64'(addr_i), 64'(e.addr));
      chk({tag, "_write"}, 64'(write_i), 64'(e.write));
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
  endtask

  task automatic aph(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic w);
    HSELS = sel; HTRANSS = tr; HADDRS = a; HWRITES = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSELS = 0; HADDRS = '0; HTRANSS = IDLE; HWRITES = 0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 0; HREADYS = 1;
    active_i = 0; readyout_i = 1; resp_i = 0;

    // Reset
    repeat (2) @(posedge HCLK);
    cyc(); HRESETn = 1'b1; #1;
    chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
    chk("rst_hresp",     64'(HRESPS),     64'd0);
    chk("rst_req",       64'(req_i),      64'd0);
    chk("rst_sel",       64'(sel_i),      64'd0);

    // Granted single write
    cyc(); aph(1, NONSEQ, 32'h2000_0010, 1); active_i = 1; #1;
    sb_q.push_back('{32'h2000_0010, 1'b1});
    chk("gnt_req", 64'(req_i), 64'd1);
    chk("gnt_rdy_aph", 64'(HREADYOUTS), 64'd1);
    sb_pop("gnt");
    cyc(); aph(0, IDLE, 32'h0, 0); active_i = 0; readyout_i = 1; #1;
    chk("gnt_rdy_dph", 64'(HREADYOUTS), 64'd1);
    chk("gnt_nohold_req", 64'(req_i), 64'd0);
    chk("gnt_nohold_sel", 64'(sel_i), 64'd0);

    // Denied for 3 cycles, locked read
    cyc(); aph(1, NONSEQ, 32'h4000_0000, 0); HMASTLOCKS = 1; active_i = 0; #1;
    sb_q.push_back('{32'h4000_0000, 1'b0});
    chk("den_req_n", 64'(req_i), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); aph(1, NONSEQ, 32'hDEAD_BEEF, 1); HMASTLOCKS = 0; HREADYS = 0;
      active_i = (i == 3); readyout_i = 0; #1;
      chk("den_addr",     64'(addr_i),     64'h4000_0000);
      chk("den_hreadyout", 64'(HREADYOUTS), 64'd0);
      chk("den_req",      64'(req_i),      64'd1);
      chk("den_lock",     64'(mastlock_i), 64'd1);
      if (i == 3) sb_pop("den");
    end
    cyc(); aph(1, IDLE, 32'h0, 0); HREADYS = 1; active_i = 0; readyout_i = 1; #1;
    chk("den_done_rdy", 64'(HREADYOUTS), 64'd1);
    chk("den_done_req", 64'(req_i), 64'd0);

    // INCR4 granted every beat, readyout alternating
    HBURSTS = 3'd3;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        cyc(); aph(1, SEQ, 32'h100 + 32'(4 * b), 1); HREADYS = 0; active_i = 0; readyout_i = 0; #1;
        chk("incr_wait", 64'(HREADYOUTS), 64'd0);
      end
      cyc(); aph(1, (b == 0) ? NONSEQ : SEQ, 32'h100 + 32'(4 * b), 1);
      HREADYS = 1; active_i = 1; readyout_i = 1; #1;
      sb_q.push_back('{32'h100 + 32'(4 * b), 1'b1});
      chk("incr_rdy", 64'(HREADYOUTS), 64'd1);
      sb_pop("incr");
    end
    cyc(); aph(1, IDLE, 32'h0, 0); HREADYS = 0; active_i = 0; readyout_i = 0; #1;
    chk("incr_last_wait", 64'(HREADYOUTS), 64'd0);
    cyc(); HREADYS = 1; readyout_i = 1; #1;
    chk("incr_last_done", 64'(HREADYOUTS), 64'd1);
    cyc(); readyout_i = 0; #1;
    chk("incr_dph_clr", 64'(HREADYOUTS), 64'd1);
    HBURSTS = 3'd0;

    // Two-cycle ERROR with cancellation of the next transfer
    cyc(); aph(1, NONSEQ, 32'h3000_0000, 0); active_i = 1; readyout_i = 1; #1;
    sb_q.push_back('{32'h3000_0000, 1'b0});
    sb_pop("err_aph");
    cyc(); aph(1, NONSEQ, 32'h3000_0004, 0); HREADYS = 0; active_i = 0; resp_i = 1; readyout_i = 0; #1;
    chk("err1_resp", 64'(HRESPS), 64'd1);
    chk("err1_rdy",  64'(HREADYOUTS), 64'd0);
    cyc(); aph(1, IDLE, 32'h3000_0004, 0); HREADYS = 1; readyout_i = 1; #1;
    chk("err2_resp", 64'(HRESPS), 64'd1);
    chk("err2_rdy",  64'(HREADYOUTS), 64'd1);
    chk("err2_req",  64'(req_i), 64'd0);
    cyc(); resp_i = 0; #1;
    chk("err_after_req",  64'(req_i), 64'd0);
    chk("err_after_rdy",  64'(HREADYOUTS), 64'd1);
    chk("err_after_resp", 64'(HRESPS), 64'd0);

    // Reset while a transfer is held
    cyc(); aph(1, NONSEQ, 32'h1000_0004, 1); active_i = 0; #1;
    cyc(); aph(1, NONSEQ, 32'h7777_0000, 0); HREADYS = 0; #1;
    chk("rsth_held_rdy",  64'(HREADYOUTS), 64'd0);
    chk("rsth_held_addr", 64'(addr_i), 64'h1000_0004);
    cyc(); HRESETn = 0; #1;
    cyc(); HRESETn = 1; aph(1, IDLE, 32'h55, 0); HREADYS = 1; #1;
    chk("rsth_rdy",  64'(HREADYOUTS), 64'd1);
    chk("rsth_req",  64'(req_i), 64'd0);
    chk("rsth_addr", 64'(addr_i), 64'h55);
    chk("rsth_resp", 64'(HRESPS), 64'd0);
    cyc(); aph(1, BUSY, 32'h58, 0); #1;
    chk("busy_trans", 64'(trans_i), 64'(BUSY));
    chk("busy_req",   64'(req_i), 64'd0);
    cyc(); aph(0, NONSEQ, 32'h60, 0); #1;
    chk("unsel_req",  64'(req_i), 64'd0);
    chk("unsel_sel",  64'(sel_i), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
